mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single byte-wide synchronous RAM port between instruction fetch (IF) and the MEM-stage load/store unit.
- Grants one requester at a time and serialises each access into 1, 2 or 4 byte cycles, little-endian.
- Returns assembled words with a one-cycle done pulse.
- MEM has priority over IF. A decoder jump aborts an in-flight fetch, so a redirected PC never waits on a stale fetch.

Parameters:
- ADDR_W, 32, width of all address ports; the RAM address is the low ADDR_W bits of the byte address.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- if_req  input  1  IF requests a 4-byte fetch; held until if_done
- if_addr  input  ADDR_W  fetch byte address
- if_inst  output  32  fetched word; valid while if_done=1
- if_done  output  1  one-cycle completion pulse to IF
- mem_req  input  1  MEM requests an access; held until mem_done
- mem_we  input  1  1=store, 0=load
- mem_width  input  2  00=byte, 01=half, 10=word, 11=word
- mem_addr  input  ADDR_W  access byte address
- mem_wdata  input  32  store data; byte k = bits [8k+7:8k]
- mem_rdata  output  32  load data, zero-extended; valid while mem_done=1
- mem_done  output  1  one-cycle completion pulse to MEM
- jump_i  input  1  jump/branch taken in ID; aborts or blocks an IF access
- busy  output  1  1 in any non-IDLE state
- ram_addr  output  ADDR_W  RAM byte address
- ram_wr  output  1  RAM write enable
- ram_dout  output  8  RAM write data
- ram_din  input  8  RAM read data; the address presented in cycle t appears in cycle t+1

Behaviour:
- Reset (rst=0, any time, including mid-access):
  - State goes to IDLE immediately (asynchronous).
  - All outputs read 0: ram_addr, ram_wr, ram_dout, if_inst, if_done, mem_rdata, mem_done, busy.
  - The partial access is discarded and no done pulse is issued.
- States: IDLE, IF_RD, MEM_RD, MEM_WR.
  - Latched per access: base address, byte count n (1/2/4), write data, and a byte counter c (0..n).
- IDLE arbitration, evaluated at each edge:
  - No grant in any cycle where if_done or mem_done is 1, because the requester is still dropping req.
  - Otherwise, if mem_req=1: latch the MEM fields; go to MEM_WR if mem_we=1, else MEM_RD. c=0.
  - Otherwise, if if_req=1 and jump_i=0: latch if_addr, n=4, go to IF_RD. c=0.
- RAM drive:
  - Combinational from the registered state: ram_addr = base + c while c<n in a busy state; otherwise 0.
  - ram_wr = 1 only in MEM_WR with c<n.
  - ram_dout = wdata byte c in MEM_WR; otherwise 0.
- Read states (IF_RD, MEM_RD):
  - c increments each edge.
  - At the edge where c≥1, ram_din is stored into result byte c-1.
  - At the edge where c=n:
    - Store the final byte and return to IDLE.
    - Register done=1 and the full result. Unused upper bytes are 0.
  - Timing: a request first visible in cycle 0 gives addresses in cycles 1..n and done in cycle n+2 (word read: done in cycle 6).
- Write state (MEM_WR):
  - One byte is written per cycle, in cycles 1..n.
  - At the edge where c=n-1, return to IDLE and register mem_done=1; done appears in cycle n+1.
- Done outputs:
  - if_done and mem_done are high for exactly one cycle.
  - if_inst and mem_rdata hold their value until the next completion of the same port, or reset.
- jump_i:
  - In IF_RD, jump_i=1 at an edge returns the FSM to IDLE, with no if_done and if_inst unchanged.
  - jump_i has no effect on MEM states.
  - In IDLE it blocks an IF grant for that edge only.
- Address arithmetic: base + c wraps modulo 2^ADDR_W.
- No misalignment check: any address is legal.
- Simultaneous mem_req and if_req in IDLE: MEM is granted; IF waits, holding if_req.

Test Plan:
- Word fetch: RAM[0x100..0x103]=13,00,50,00, if_req=1, if_addr=0x100 → ram_addr 0x100..0x103 in cycles 1-4, if_done cycle 6 with if_inst=0x00500013, busy high cycles 1-5.
- Byte/half load: mem_width=00 at 0x7 (RAM=0xF0) → mem_rdata=0x000000F0, done cycle 3; mem_width=01 at 0x6 (RAM 0x34,0x12) → 0x00001234, done cycle 4.
- Word store: mem_we=1, mem_width=10, addr 0x200, wdata 0xDEADBEEF → ram_wr high cycles 1-4 writing EF,BE,AD,DE to 0x200..0x203, mem_done cycle 5; readback yields 0xDEADBEEF.
- Contention: if_req and mem_req both rise in cycle 0 → MEM load served first; IF fetch starts only after mem_done has dropped; if_done follows with correct data.
- Fetch abort: jump_i pulsed in cycle 3 of a fetch → FSM in IDLE in cycle 4, no if_done, if_inst unchanged; the re-issued if_req with a new address completes normally.
- Reset mid-store: rst=0 in cycle 2 of a word store → ram_wr=0 and busy=0 immediately, no mem_done; after rst=1 the next request is served from IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the byte-wide RAM and the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_inst;
  logic              if_done;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_width;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic              jump_i;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_width, mem_addr, mem_wdata,
           jump_i, ram_din,
    output if_inst, if_done, mem_rdata, mem_done, busy, ram_addr, ram_wr, ram_dout
  );

  // Requester / RAM side
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_width, mem_addr, mem_wdata,
           jump_i, ram_din,
    input  if_inst, if_done, mem_rdata, mem_done, busy, ram_addr, ram_wr, ram_dout
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one synchronous RAM port between instruction
// fetch and the MEM-stage load/store unit. MEM wins ties; a jump aborts a fetch.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_IF_RD  = 2'd1;
  localparam logic [1:0] ST_MEM_RD = 2'd2;
  localparam logic [1:0] ST_MEM_WR = 2'd3;

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [2:0]        cnt_reg;
  logic [2:0]        len_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       acc_reg;
  logic [31:0]       if_inst_reg;
  logic [31:0]       mem_rdata_reg;
  logic              if_done_reg;
  logic              mem_done_reg;

  logic [2:0]        mem_len;
  logic [31:0]       acc_merged;
  logic [31:0]       wdata_shift;
  logic              in_range;

  // Byte count of the MEM access: 11 is treated as a word like 10.
  always_comb begin
    mem_len = 3'd4;
    case (bus.mem_width)
      2'b00:   mem_len = 3'd1;
      2'b01:   mem_len = 3'd2;
      default: mem_len = 3'd4;
    endcase
  end

  // Read data for address c-1 arrives while c is current; fold it into its byte lane.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign acc_merged[8*gi +: 8] = (cnt_reg == 3'(gi + 1)) ? bus.ram_din
                                                              : acc_reg[8*gi +: 8];
    end
  endgenerate

  assign in_range    = (state_reg != ST_IDLE) && (cnt_reg < len_reg);
  assign wdata_shift = wdata_reg >> {cnt_reg[1:0], 3'b000};

  // RAM port is driven purely from registered state, so it is 0 whenever idle.
  always_comb begin
    bus.ram_addr = '0;
    bus.ram_wr   = 1'b0;
    bus.ram_dout = 8'h00;
    if (in_range) begin
      bus.ram_addr = base_reg + ADDR_W'(cnt_reg);
    end
    if (state_reg == ST_MEM_WR) begin
      bus.ram_wr   = in_range;
      bus.ram_dout = wdata_shift[7:0];
    end
  end

  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.if_inst   = if_inst_reg;
  assign bus.if_done   = if_done_reg;
  assign bus.mem_rdata = mem_rdata_reg;
  assign bus.mem_done  = mem_done_reg;

  // Arbitration, byte sequencing and result/done registration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      base_reg      <= '0;
      cnt_reg       <= 3'd0;
      len_reg       <= 3'd0;
      wdata_reg     <= 32'h0;
      acc_reg       <= 32'h0;
      if_inst_reg   <= 32'h0;
      mem_rdata_reg <= 32'h0;
      if_done_reg   <= 1'b0;
      mem_done_reg  <= 1'b0;
    end else begin
      if_done_reg  <= 1'b0;
      mem_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // A requester seeing done is still dropping req this cycle; do not regrant.
          if (!if_done_reg && !mem_done_reg) begin
            if (bus.mem_req) begin
              base_reg  <= bus.mem_addr;
              len_reg   <= mem_len;
              wdata_reg <= bus.mem_wdata;
              cnt_reg   <= 3'd0;
              acc_reg   <= 32'h0;
              state_reg <= bus.mem_we ? ST_MEM_WR : ST_MEM_RD;
            end else if (bus.if_req && !bus.jump_i) begin
              base_reg  <= bus.if_addr;
              len_reg   <= 3'd4;
              cnt_reg   <= 3'd0;
              acc_reg   <= 32'h0;
              state_reg <= ST_IF_RD;
            end
          end
        end
        ST_IF_RD, ST_MEM_RD: begin
          if ((state_reg == ST_IF_RD) && bus.jump_i) begin
            // Redirected PC: drop the stale fetch without touching if_inst.
            state_reg <= ST_IDLE;
          end else begin
            acc_reg <= acc_merged;
            cnt_reg <= cnt_reg + 3'd1;
            if (cnt_reg == len_reg) begin
              state_reg <= ST_IDLE;
              if (state_reg == ST_IF_RD) begin
                if_inst_reg <= acc_merged;
                if_done_reg <= 1'b1;
              end else begin
                mem_rdata_reg <= acc_merged;
                mem_done_reg  <= 1'b1;
              end
            end
          end
        end
        ST_MEM_WR: begin
          cnt_reg <= cnt_reg + 3'd1;
          // Writes need no read-back latency, so finish as the last byte goes out.
          if (cnt_reg == (len_reg - 3'd1)) begin
            state_reg    <= ST_IDLE;
            mem_done_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-indexed expectation timeline built from
// transaction-level timing rules, checked every cycle, plus literal data pins.
module tb_mem_arbiter;
  localparam int NCYC = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycle c is the interval following the c-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference memory (model view) and the simulated synchronous RAM.
  logic [7:0] ref_mem [4096];
  logic [7:0] ram     [4096];
  bit         ram_loaded = 1'b0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 4096; i++) ram[i] <= ref_mem[i];
      ram_loaded <= 1'b1;
    end else if (bus.ram_wr) begin
      ram[bus.ram_addr[11:0]] <= bus.ram_dout;
    end
    bus.ram_din <= ram[bus.ram_addr[11:0]];
  end

  // Expected outputs per cycle.
  logic        exp_busy [NCYC];
  logic [31:0] exp_addr [NCYC];
  logic        exp_wr   [NCYC];
  logic [7:0]  exp_dout [NCYC];
  logic        exp_ifd  [NCYC];
  logic [31:0] exp_ifw  [NCYC];
  logic        exp_memd [NCYC];
  logic        exp_mupd [NCYC];
  logic [31:0] exp_memw [NCYC];
  logic [31:0] model_if  = 32'h0;
  logic [31:0] model_mem = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_plan(input int from, input int to);
    for (int c = from; c <= to; c++) begin
      exp_busy[c] = 1'b0; exp_addr[c] = 32'h0; exp_wr[c] = 1'b0; exp_dout[c] = 8'h0;
      exp_ifd[c] = 1'b0; exp_ifw[c] = 32'h0; exp_memd[c] = 1'b0; exp_mupd[c] = 1'b0;
      exp_memw[c] = 32'h0;
    end
  endtask

  // Read granted off cycle c0: addresses in c0+1..c0+n, done in c0+n+2.
  task automatic plan_read(input int c0, input bit is_if, input logic [31:0] a, input int n);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < n; k++) begin
      w = w | (32'(ref_mem[12'(a + 32'(k))]) << (8 * k));
      exp_busy[c0 + k + 1] = 1'b1;
      exp_addr[c0 + k + 1] = a + 32'(k);
    end
    exp_busy[c0 + n + 1] = 1'b1;
    if (is_if) begin
      exp_ifd[c0 + n + 2] = 1'b1; exp_ifw[c0 + n + 2] = w;
    end else begin
      exp_memd[c0 + n + 2] = 1'b1; exp_mupd[c0 + n + 2] = 1'b1; exp_memw[c0 + n + 2] = w;
    end
  endtask

  // Write granted off cycle c0: bytes in c0+1..c0+n, done in c0+n+1.
  task automatic plan_write(input int c0, input logic [31:0] a, input int n,
                            input logic [31:0] wd, input bit commit);
    for (int k = 0; k < n; k++) begin
      exp_busy[c0 + k + 1] = 1'b1;
      exp_addr[c0 + k + 1] = a + 32'(k);
      exp_wr[c0 + k + 1]   = 1'b1;
      exp_dout[c0 + k + 1] = 8'(wd >> (8 * k));
      if (commit) ref_mem[12'(a + 32'(k))] = 8'(wd >> (8 * k));
    end
    exp_memd[c0 + n + 1] = 1'b1;
  endtask

  // Per-cycle comparison of every output against the timeline.
  always @(negedge clk) begin
    if (cyc < NCYC) begin
      if (!rst) begin
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_ram_addr", bus.ram_addr, 32'h0);
        check("rst_ram_wr", 32'(bus.ram_wr), 32'h0);
        check("rst_ram_dout", 32'(bus.ram_dout), 32'h0);
        check("rst_if_done", 32'(bus.if_done), 32'h0);
        check("rst_mem_done", 32'(bus.mem_done), 32'h0);
        check("rst_if_inst", bus.if_inst, 32'h0);
        check("rst_mem_rdata", bus.mem_rdata, 32'h0);
        model_if  <= 32'h0;
        model_mem <= 32'h0;
      end else begin
        check("busy", 32'(bus.busy), 32'(exp_busy[cyc]));
        check("ram_addr", bus.ram_addr, exp_addr[cyc]);
        check("ram_wr", 32'(bus.ram_wr), 32'(exp_wr[cyc]));
        check("ram_dout", 32'(bus.ram_dout), 32'(exp_dout[cyc]));
        check("if_done", 32'(bus.if_done), 32'(exp_ifd[cyc]));
        check("mem_done", 32'(bus.mem_done), 32'(exp_memd[cyc]));
        check("if_inst", bus.if_inst, exp_ifd[cyc] ? exp_ifw[cyc] : model_if);
        check("mem_rdata", bus.mem_rdata, exp_mupd[cyc] ? exp_memw[cyc] : model_mem);
        model_if  <= exp_ifd[cyc] ? exp_ifw[cyc] : model_if;
        model_mem <= exp_mupd[cyc] ? exp_memw[cyc] : model_mem;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input bit is_if, input logic [31:0] a, input logic [1:0] w, input int n);
    int c0;
    c0 = cyc;
    if (is_if) begin
      bus.if_req = 1'b1; bus.if_addr = a;
    end else begin
      bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_width = w; bus.mem_addr = a;
    end
    plan_read(c0, is_if, a, n);
    repeat (n + 2) step();
    bus.if_req = 1'b0; bus.mem_req = 1'b0;
    step();
    $display("read  %s addr=%h n=%0d if_inst=%h mem_rdata=%h", is_if ? "IF " : "MEM",
             a, n, bus.if_inst, bus.mem_rdata);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [1:0] w, input int n,
                          input logic [31:0] wd);
    int c0;
    c0 = cyc;
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_width = w;
    bus.mem_addr = a; bus.mem_wdata = wd;
    plan_write(c0, a, n, wd, 1'b1);
    repeat (n + 1) step();
    bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    step();
    $display("write MEM addr=%h n=%0d wdata=%h", a, n, wd);
  endtask

  initial begin : stim
    int c0;
    clear_plan(0, NCYC - 1);
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    ref_mem[12'h100] = 8'h13; ref_mem[12'h101] = 8'h00;
    ref_mem[12'h102] = 8'h50; ref_mem[12'h103] = 8'h00;
    ref_mem[12'h104] = 8'h93; ref_mem[12'h105] = 8'h00;
    ref_mem[12'h106] = 8'h10; ref_mem[12'h107] = 8'h00;
    ref_mem[12'h108] = 8'h13; ref_mem[12'h109] = 8'h01;
    ref_mem[12'h10A] = 8'h20; ref_mem[12'h10B] = 8'h00;
    ref_mem[12'h006] = 8'h34; ref_mem[12'h007] = 8'hF0;
    ref_mem[12'hFFF] = 8'hAB; ref_mem[12'h000] = 8'hCD;
    bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    bus.mem_width = 2'b00; bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0; bus.jump_i = 1'b0;

    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();

    // Word fetch
    do_read(1'b1, 32'h100, 2'b10, 4);
    check("lit_word_fetch", bus.if_inst, 32'h00500013);

    // Byte load; jump_i held high must not disturb a MEM access
    bus.jump_i = 1'b1;
    do_read(1'b0, 32'h7, 2'b00, 1);
    bus.jump_i = 1'b0;
    check("lit_byte_load", bus.mem_rdata, 32'h000000F0);

    // Byte store then half load across it
    do_write(32'h7, 2'b00, 1, 32'hAABBCC12);
    do_read(1'b0, 32'h6, 2'b01, 2);
    check("lit_half_load", bus.mem_rdata, 32'h00001234);

    // Word store and readback; width 11 also reads a word
    do_write(32'h200, 2'b10, 4, 32'hDEADBEEF);
    do_read(1'b0, 32'h200, 2'b11, 4);
    check("lit_store_readback", bus.mem_rdata, 32'hDEADBEEF);

    // Address wrap: half at the top of the address space
    do_read(1'b0, 32'hFFFFFFFF, 2'b01, 2);
    check("lit_wrap_half", bus.mem_rdata, 32'h0000CDAB);

    // Contention: MEM byte load first, IF word fetch after mem_done drops
    c0 = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_width = 2'b00; bus.mem_addr = 32'h6;
    plan_read(c0, 1'b0, 32'h6, 1);
    plan_read(c0 + 4, 1'b1, 32'h100, 4);
    repeat (3) step();
    bus.mem_req = 1'b0;
    check("lit_contention_mem", bus.mem_rdata, 32'h00000034);
    repeat (7) step();
    bus.if_req = 1'b0;
    check("lit_contention_if", bus.if_inst, 32'h00500013);
    step();
    $display("contention done: mem_rdata=%h if_inst=%h", bus.mem_rdata, bus.if_inst);

    // Fetch abort by jump in cycle 3, then redirected fetch
    c0 = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    plan_read(c0, 1'b1, 32'h104, 4);
    repeat (3) step();
    bus.jump_i = 1'b1; bus.if_addr = 32'h108;
    step();
    bus.jump_i = 1'b0;
    clear_plan(c0 + 4, c0 + 6);
    plan_read(c0 + 4, 1'b1, 32'h108, 4);
    check("lit_abort_idle", 32'(bus.busy), 32'h0);
    check("lit_abort_inst_held", bus.if_inst, 32'h00500013);
    repeat (6) step();
    bus.if_req = 1'b0;
    check("lit_redirect_fetch", bus.if_inst, 32'h00200113);
    step();
    $display("abort/redirect done: if_inst=%h", bus.if_inst);

    // jump_i in IDLE blocks the IF grant for one edge only
    c0 = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h104; bus.jump_i = 1'b1;
    step();
    bus.jump_i = 1'b0;
    plan_read(c0 + 1, 1'b1, 32'h104, 4);
    repeat (6) step();
    bus.if_req = 1'b0;
    check("lit_jump_idle_fetch", bus.if_inst, 32'h00100093);
    step();
    $display("idle-jump fetch done: if_inst=%h", bus.if_inst);

    // Reset in cycle 2 of a word store, then a fresh load
    c0 = cyc;
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_width = 2'b10;
    bus.mem_addr = 32'h300; bus.mem_wdata = 32'h11223344;
    plan_write(c0, 32'h300, 4, 32'h11223344, 1'b0);
    repeat (2) step();
    rst = 1'b0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    clear_plan(c0 + 2, c0 + 6);
    #1;
    check("lit_rst_ram_wr", 32'(bus.ram_wr), 32'h0);
    check("lit_rst_busy", 32'(bus.busy), 32'h0);
    step();
    rst = 1'b1;
    step();
    $display("reset mid-store applied");
    do_read(1'b0, 32'h200, 2'b10, 4);
    check("lit_after_reset_load", bus.mem_rdata, 32'hDEADBEEF);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
